// File: rtl/sprite_line_scheduler_if.sv
// Handshake/status bundle between display timing, sprite renderer and line buffer.
interface sprite_line_scheduler_if #(
    parameter int unsigned LINE_W = 10,
    parameter int unsigned CNT_W  = 8
);
    logic              enable;
    logic              line_start;
    logic              line_end;
    logic [LINE_W-1:0] next_line_idx;
    logic              renderer_done;
    logic              status_clr;
    logic              renderer_start;
    logic              renderer_abort;
    logic [LINE_W-1:0] render_line;
    logic              active_render_buffer;
    logic              composer_erase_start;
    logic              erase_busy;
    logic [CNT_W-1:0]  overrun_count;
    logic              overrun_flag;
    logic              erase_collision_flag;

    // Timing/composer/renderer side: drives the control inputs, observes status.
    modport master (
        output enable, line_start, line_end, next_line_idx, renderer_done, status_clr,
        input  renderer_start, renderer_abort, render_line, active_render_buffer,
               composer_erase_start, erase_busy, overrun_count, overrun_flag,
               erase_collision_flag
    );

    // Scheduler side.
    modport slave (
        input  enable, line_start, line_end, next_line_idx, renderer_done, status_clr,
        output renderer_start, renderer_abort, render_line, active_render_buffer,
               composer_erase_start, erase_busy, overrun_count, overrun_flag,
               erase_collision_flag
    );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sequencer for the double-buffered sprite line buffer: swaps halves,
// kicks the renderer, erases the displayed half and tracks overrun/collision status.
module sprite_line_scheduler #(
    parameter int unsigned ERASE_LEN = 160,
    parameter int unsigned LINE_W    = 10,
    parameter int unsigned CNT_W     = 8
) (
    input logic                    clk,
    input logic                    rst,
    sprite_line_scheduler_if.slave bus
);
    localparam int unsigned ERASE_CW = $clog2(ERASE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RENDERING = 2'd1,
        DONE      = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   swap_c, abort_c, overrun_c;

    logic                renderer_start_q;
    logic                renderer_abort_q;
    logic [LINE_W-1:0]   render_line_q;
    logic                active_buf_q;
    logic                erase_start_q;
    logic                erase_busy_q;
    logic [ERASE_CW-1:0] erase_cnt_q;
    logic [CNT_W-1:0]    overrun_cnt_q;
    logic                overrun_flag_q;
    logic                collision_flag_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state plus swap/abort/overrun decisions for this cycle.
    always_comb begin
        state_d   = state_q;
        swap_c    = 1'b0;
        abort_c   = 1'b0;
        overrun_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && bus.line_start) begin
                    swap_c  = 1'b1;
                    state_d = RENDERING;
                end
            end
            RENDERING: begin
                if (!bus.enable) begin
                    abort_c = 1'b1;
                    state_d = IDLE;
                end else if (bus.line_start) begin
                    // A done pulse coinciding with the swap still counts as on time.
                    swap_c = 1'b1;
                    if (!bus.renderer_done) begin
                        abort_c   = 1'b1;
                        overrun_c = 1'b1;
                    end
                end else if (bus.renderer_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (bus.line_start) begin
                    swap_c  = 1'b1;
                    state_d = RENDERING;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Renderer control and buffer ownership.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            renderer_start_q <= 1'b0;
            renderer_abort_q <= 1'b0;
            render_line_q    <= '0;
            active_buf_q     <= 1'b0;
        end else begin
            renderer_start_q <= swap_c;
            renderer_abort_q <= abort_c;
            if (swap_c) begin
                active_buf_q  <= ~active_buf_q;
                render_line_q <= bus.next_line_idx;
            end
        end
    end

    // Erase sequencer: busy for ERASE_LEN cycles after line_end, retriggerable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            erase_start_q <= 1'b0;
            erase_busy_q  <= 1'b0;
            erase_cnt_q   <= '0;
        end else if (bus.line_end) begin
            erase_start_q <= 1'b1;
            erase_busy_q  <= 1'b1;
            erase_cnt_q   <= ERASE_CW'(ERASE_LEN - 1);
        end else begin
            erase_start_q <= 1'b0;
            if (erase_cnt_q != '0) erase_cnt_q  <= erase_cnt_q - 1'b1;
            else                   erase_busy_q <= 1'b0;
        end
    end

    // Sticky status; clear takes priority over a same-cycle event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_cnt_q    <= '0;
            overrun_flag_q   <= 1'b0;
            collision_flag_q <= 1'b0;
        end else if (bus.status_clr) begin
            overrun_cnt_q    <= '0;
            overrun_flag_q   <= 1'b0;
            collision_flag_q <= 1'b0;
        end else begin
            if (overrun_c) begin
                overrun_flag_q <= 1'b1;
                if (overrun_cnt_q != CNT_MAX) overrun_cnt_q <= overrun_cnt_q + 1'b1;
            end
            if (swap_c && erase_busy_q) collision_flag_q <= 1'b1;
        end
    end

    assign bus.renderer_start       = renderer_start_q;
    assign bus.renderer_abort       = renderer_abort_q;
    assign bus.render_line          = render_line_q;
    assign bus.active_render_buffer = active_buf_q;
    assign bus.composer_erase_start = erase_start_q;
    assign bus.erase_busy           = erase_busy_q;
    assign bus.overrun_count        = overrun_cnt_q;
    assign bus.overrun_flag         = overrun_flag_q;
    assign bus.erase_collision_flag = collision_flag_q;
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: directed scenarios plus random traffic, all
// outputs compared every cycle against a line-level behavioural model.
module tb_sprite_line_scheduler;
    localparam int unsigned ERASE_LEN = 160;
    localparam int unsigned LINE_W    = 10;
    localparam int unsigned CNT_W     = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    sprite_line_scheduler_if #(.LINE_W(LINE_W), .CNT_W(CNT_W)) bus ();

    sprite_line_scheduler #(.ERASE_LEN(ERASE_LEN), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: is the scheduler engaged, and is a render still outstanding.
    bit engaged, pending;
    int cyc;
    int erase_from, erase_to;
    bit m_start, m_abort, m_buf, m_estart, m_flag, m_coll;
    int m_line, m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit model_busy(input int n);
        return (n >= erase_from) && (n <= erase_to);
    endfunction

    task automatic check_all();
        check("renderer_start", 32'(bus.renderer_start), 32'(m_start));
        check("renderer_abort", 32'(bus.renderer_abort), 32'(m_abort));
        check("render_line", 32'(bus.render_line), 32'(m_line));
        check("active_buf", 32'(bus.active_render_buffer), 32'(m_buf));
        check("erase_start", 32'(bus.composer_erase_start), 32'(m_estart));
        check("erase_busy", 32'(bus.erase_busy), 32'(model_busy(cyc)));
        check("overrun_count", 32'(bus.overrun_count), 32'(m_cnt));
        check("overrun_flag", 32'(bus.overrun_flag), 32'(m_flag));
        check("collision_flag", 32'(bus.erase_collision_flag), 32'(m_coll));
    endtask

    task automatic model_reset();
        engaged = 0; pending = 0;
        m_start = 0; m_abort = 0; m_buf = 0; m_estart = 0; m_flag = 0; m_coll = 0;
        m_line = 0; m_cnt = 0;
        erase_from = 0; erase_to = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.enable = 0; bus.line_start = 0; bus.line_end = 0;
        bus.renderer_done = 0; bus.status_clr = 0; bus.next_line_idx = '0;
        @(posedge clk); #1;
        model_reset();
        check_all();
        rst = 1'b0;
    endtask

    // One clock: apply inputs, advance the model, compare after the edge.
    task automatic step(input bit en, input bit ls, input bit le, input bit rd,
                        input bit clr, input int idx);
        bit swap, ovr, abort, busy_now;
        bus.enable = en; bus.line_start = ls; bus.line_end = le;
        bus.renderer_done = rd; bus.status_clr = clr;
        bus.next_line_idx = LINE_W'(idx);
        busy_now = model_busy(cyc);
        swap = 0; ovr = 0; abort = 0;
        if (!engaged) begin
            swap = en && ls;
        end else if (!en) begin
            abort = pending;
            engaged = 0;
            pending = 0;
        end else if (ls) begin
            swap = 1;
            if (pending && !rd) begin ovr = 1; abort = 1; end
        end else if (rd) begin
            pending = 0;
        end
        if (swap) begin
            engaged = 1; pending = 1;
            m_buf = !m_buf;
            m_line = idx % (1 << LINE_W);
        end
        m_start = swap;
        m_abort = abort;
        if (clr) begin
            m_cnt = 0; m_flag = 0; m_coll = 0;
        end else begin
            if (ovr) begin
                m_flag = 1;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
            if (swap && busy_now) m_coll = 1;
        end
        cyc++;
        m_estart = le;
        if (le) begin
            erase_from = cyc;
            erase_to   = cyc + ERASE_LEN - 1;
        end
        @(posedge clk); #1;
        check_all();
    endtask

    initial begin
        int busy_cycles;
        bit en_r;
        cyc = 0;
        do_reset();

        // First swap from IDLE.
        step(1, 1, 0, 0, 0, 5);
        check("first_buf", 32'(bus.active_render_buffer), 32'd1);
        check("first_start", 32'(bus.renderer_start), 32'd1);
        check("first_line", 32'(bus.render_line), 32'd5);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 6);
        check("ontime_buf", 32'(bus.active_render_buffer), 32'd0);
        check("ontime_abort", 32'(bus.renderer_abort), 32'd0);
        check("ontime_cnt", 32'(bus.overrun_count), 32'd0);

        // Overrun and clear.
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 7);
        check("ovr_abort", 32'(bus.renderer_abort), 32'd1);
        check("ovr_cnt", 32'(bus.overrun_count), 32'd1);
        step(1, 0, 0, 0, 1, 0);
        check("clr_cnt", 32'(bus.overrun_count), 32'd0);

        // Erase length and collision.
        step(1, 0, 1, 0, 0, 0);
        busy_cycles = 1;
        for (int i = 0; i < 200; i++) begin
            step(1, i == 48, 0, i == 10, 0, 9);
            if (bus.erase_busy) busy_cycles++;
        end
        check("erase_len", 32'(busy_cycles), 32'(ERASE_LEN));
        check("collision", 32'(bus.erase_collision_flag), 32'd1);

        // Saturation, then on-time done coinciding with swap.
        step(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 256; i++) step(1, 1, 0, 0, 0, i);
        check("sat_cnt", 32'(bus.overrun_count), 32'(CNT_MAX));
        step(1, 1, 0, 1, 0, 300);
        check("done_same_abort", 32'(bus.renderer_abort), 32'd0);

        // Disable while rendering.
        step(0, 0, 0, 0, 0, 0);
        check("dis_abort", 32'(bus.renderer_abort), 32'd1);
        step(0, 1, 0, 0, 0, 11);
        check("dis_start", 32'(bus.renderer_start), 32'd0);
        step(0, 0, 1, 0, 0, 0);
        check("dis_erase", 32'(bus.composer_erase_start), 32'd1);

        // Reset mid-erase, then random traffic.
        step(1, 1, 0, 0, 0, 3);
        do_reset();
        en_r = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) en_r = !en_r;
            step(en_r, $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0,
                 int'($urandom_range(0, 1023)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
